sio_tx_1x: RTL and testbench

- Serial transmitter for the 1-bit-per-clock remote IO link.
- Accepts NBI-bit parallel words on a valid/ready handshake and frames each word as: start bit 0, then NBI data bits MSB first, then at least GAP idle ones.
- Output q drives the pin serializer at 1 bit per clock (400 MHz = 400 Mb/s); the far end is the 4x-oversampled data recovery receiver.
- Line idles high.

---
 rtl/sio_tx_1x.sv | 171 +++++++++++++++++
 tb/tb_sio_tx_1x.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_tx_1x.sv
// sio_tx_1x -- serial transmitter for the 1-bit-per-clock remote IO link.
//
// Frames each accepted NBI-bit word as: start bit (0), NBI data bits MSB
// first, then at least GAP idle ones. The line idles high. All outputs are
// registered: every output register is loaded from the next-state value, so
// the start bit appears on q the cycle after the accepting edge.
//
// Optional build macro SIO_TX_HOLD_EN adds a one-word holding register so a
// word can be accepted while a frame is on the line. Back-to-back frames are
// then separated by exactly GAP ones instead of GAP+1.
//
// Ports:
//   c      in   clock (400 MHz, one line bit per clock)
//   rn     in   synchronous active-low reset
//   d      in   [NBI-1:0] word to send, bit NBI-1 first
//   v      in   d valid
//   ready  out  word accepted on a cycle with v && ready
//   q      out  serial line bit, idle 1
//   sop    out  one-cycle pulse coincident with the start bit on q
//   busy   out  frame in progress or a word held
module sio_tx_1x #(
    parameter int NBI = 16,
    parameter int GAP = 4
) (
    input  logic           c,
    input  logic           rn,
    input  logic [NBI-1:0] d,
    input  logic           v,
    output logic           ready,
    output logic           q,
    output logic           sop,
    output logic           busy
);

    localparam int BW = $clog2(NBI + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;

    state_t         state_reg,   state_next;
    logic [NBI-1:0] shift_reg,   shift_next;
    logic [BW-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [3:0]     gap_cnt_reg, gap_cnt_next;
    logic           q_reg,       q_next;
    logic           sop_reg,     sop_next;
    logic           ready_reg,   ready_next;
    logic           busy_reg,    busy_next;
    logic           accept;
`ifdef SIO_TX_HOLD_EN
    logic [NBI-1:0] hold_reg,      hold_next;
    logic           hold_full_reg, hold_full_next;
`endif

    assign accept = v && ready_reg;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        q_next       = 1'b1;
        sop_next     = 1'b0;
`ifdef SIO_TX_HOLD_EN
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        // Any accept while a frame is on the line parks the word; the
        // end-of-gap branch below may redirect it straight to the shifter.
        if (accept && state_reg != S_IDLE) begin
            hold_next      = d;
            hold_full_next = 1'b1;
        end
`endif
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    shift_next = d;
                    state_next = S_START;
                    q_next     = 1'b0;
                    sop_next   = 1'b1;
                end
            end
            S_START: begin
                state_next   = S_DATA;
                q_next       = shift_reg[NBI-1];
                shift_next   = shift_reg << 1;
                bit_cnt_next = BW'(1);
            end
            S_DATA: begin
                if (bit_cnt_reg == BW'(NBI)) begin
                    state_next   = S_GAP;
                    gap_cnt_next = 4'd1;
                end else begin
                    q_next       = shift_reg[NBI-1];
                    shift_next   = shift_reg << 1;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == 4'(GAP)) begin
                    state_next = S_IDLE;
`ifdef SIO_TX_HOLD_EN
                    if (hold_full_reg) begin
                        // Held word moves to the shifter; a simultaneous
                        // accept refills the holding register.
                        state_next     = S_START;
                        shift_next     = hold_reg;
                        q_next         = 1'b0;
                        sop_next       = 1'b1;
                        hold_full_next = accept;
                    end else if (accept) begin
                        // Word arriving exactly at the end of the gap skips
                        // the holding register, otherwise it would be
                        // stranded in IDLE.
                        state_next     = S_START;
                        shift_next     = d;
                        q_next         = 1'b0;
                        sop_next       = 1'b1;
                        hold_next      = hold_reg;
                        hold_full_next = 1'b0;
                    end
`endif
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
`ifdef SIO_TX_HOLD_EN
        ready_next = !hold_full_next;
        busy_next  = (state_next != S_IDLE) || hold_full_next;
`else
        ready_next = (state_next == S_IDLE);
        busy_next  = (state_next != S_IDLE);
`endif
    end

    always_ff @(posedge c) begin
        if (!rn) begin
            state_reg     <= S_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            q_reg         <= 1'b1;
            sop_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef SIO_TX_HOLD_EN
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            q_reg         <= q_next;
            sop_reg       <= sop_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
`ifdef SIO_TX_HOLD_EN
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
`endif
        end
    end

    assign ready = ready_reg;
    assign q     = q_reg;
    assign sop   = sop_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_sio_tx_1x.sv
// tb_sio_tx_1x -- scoreboard bench for sio_tx_1x (NBI=16, GAP=4).
// Stimulus pushes the expected frame (data, exact gap, start-bit cycle) into a
// queue on every accept; a line monitor decodes q on the falling edge, pops
// an entry at each start bit and compares. Works for both builds
// (SIO_TX_HOLD_EN defined or not).
module tb_sio_tx_1x;

    localparam int NBI = 16;
    localparam int GAP = 4;
`ifdef SIO_TX_HOLD_EN
    localparam int HOLD = 1;
`else
    localparam int HOLD = 0;
`endif
    // Ones between the last data bit and the next start bit when words are
    // offered continuously.
    localparam int B2B_GAP = (HOLD != 0) ? GAP : GAP + 1;

    logic        c = 1'b0;
    logic        rn = 1'b0;
    logic        v = 1'b0;
    logic [15:0] d = '0;
    logic        ready, q, sop, busy;

    sio_tx_1x #(.NBI(NBI), .GAP(GAP)) dut (
        .c(c), .rn(rn), .d(d), .v(v),
        .ready(ready), .q(q), .sop(sop), .busy(busy)
    );

    always #5 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          gap_exact;   // -1: not checked
        int          acc_edge;    // -1: not checked
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- line monitor ----------------
    initial begin
        logic        rn_prev;
        logic        collecting;
        logic        junk;
        logic        gap_known;
        logic [15:0] word;
        int          nbits;
        int          ones_run;
        int          last_gap;
        exp_t        cur;
        rn_prev = 1'b1; collecting = 1'b0; junk = 1'b0; gap_known = 1'b0;
        word = '0; nbits = 0; ones_run = 0; last_gap = 0;
        cur.data = '0; cur.gap_exact = -1; cur.acc_edge = -1;
        forever begin
            @(negedge c);
            if (!rn_prev) begin
                // Previous posedge saw rn=0, so outputs show reset values.
                check("rst_q", q, 1);
                check("rst_sop", sop, 0);
                check("rst_ready", ready, 0);
                check("rst_busy", busy, 0);
            end
            if (!rn || !rn_prev) begin
                collecting = 1'b0; junk = 1'b0; gap_known = 1'b0; ones_run = 0;
            end else begin
                check("sop", sop, (!collecting && q == 1'b0) ? 1 : 0);
                if (collecting) begin
                    word = {word[14:0], q};
                    nbits++;
                    if (nbits == NBI) begin
                        collecting = 1'b0;
                        ones_run = 0;
                        gap_known = 1'b1;
                        if (!junk) begin
                            check("data", word, cur.data);
                            $display("frame rx %04h exp %04h gap_before %0d cycle %0d",
                                     word, cur.data, last_gap, cyc);
                        end
                        junk = 1'b0;
                    end
                end else if (q == 1'b1) begin
                    ones_run++;
                end else begin
                    collecting = 1'b1;
                    nbits = 0;
                    last_gap = ones_run;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        junk = 1'b1;
                        $display("FAIL unexpected_start: start bit with nothing queued (cycle %0d)", cyc);
                    end else begin
                        cur = sb.pop_front();
                        if (gap_known) check("min_gap", (ones_run >= B2B_GAP) ? 1 : 0, 1);
                        if (gap_known && cur.gap_exact >= 0) check("gap", ones_run, cur.gap_exact);
                        if (cur.acc_edge >= 0) check("latency", cyc, cur.acc_edge);
                    end
                end
            end
            rn_prev = rn;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // Offer w with v=1 until accepted; returns with v still high, just after
    // the accepting edge.
    task automatic send(input logic [15:0] w, input int gap_exact, input bit lat, output int acc);
        int   t;
        exp_t e;
        d = w;
        v = 1'b1;
        t = 0;
        acc = -1;
        while (!ready && t < 200) begin
            tick();
            t++;
        end
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: word %04h never accepted (cycle %0d)", w, cyc);
            v = 1'b0;
        end else begin
            e.data = w;
            e.gap_exact = gap_exact;
            e.acc_edge = lat ? cyc + 1 : -1;
            sb.push_back(e);
            tick();
            acc = cyc;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 1000) begin
            tick();
            t++;
        end
        check("drain", (sb.size() == 0 && !busy) ? 1 : 0, 1);
        repeat (3) tick();
    endtask

    initial begin
        int a0, a1, t;
        bit first;
        // Reset, then idle.
        rn = 1'b0;
        repeat (4) tick();
        check("ready_in_reset", ready, 0);
        rn = 1'b1;
        check("ready_release_edge", ready, 0);
        tick();
        check("ready_after_release", ready, 1);
        check("busy_after_release", busy, 0);
        check("q_after_release", q, 1);

        // Single frame A5C3; d changes right after accept.
        send(16'hA5C3, -1, 1'b1, a0);
        v = 1'b0;
        d = 16'h1234;
        check("ready_after_accept", ready, HOLD);
        check("busy_in_frame", busy, 1);
        drain();
        check("busy_idle", busy, 0);
        check("ready_idle", ready, 1);

        // Back-to-back 8001 then 7FFE with v held high.
        send(16'h8001, -1, 1'b1, a0);
        send(16'h7FFE, B2B_GAP, (HOLD == 0), a1);
        v = 1'b0;
`ifdef SIO_TX_HOLD_EN
        check("hold_accept_edge", a1, a0 + 1);
        check("ready_hold_full", ready, 0);
        check("busy_hold_full", busy, 1);
        t = 0;
        while (!ready && t < 100) begin
            tick();
            t++;
        end
        check("ready_rise_edge", cyc, a0 + NBI + GAP + 1);
`else
        check("second_accept_edge", a1, a0 + NBI + GAP + 2);
`endif
        drain();

        // Reset during data bit 7 of 0000 (plus a held FFFF in the hold build).
        send(16'h0000, -1, 1'b1, a0);
        if (HOLD != 0) send(16'hFFFF, -1, 1'b0, a1);
        v = 1'b0;
        while (cyc < a0 + 7) tick();
        rn = 1'b0;
        sb.delete();
        repeat (2) tick();
        rn = 1'b1;
        repeat (40) tick();
        check("busy_after_abort", busy, 0);
        check("q_after_abort", q, 1);
        check("ready_after_abort", ready, 1);

        // 100 random words, mostly continuous, with occasional full idles.
        first = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 25 == 0 && i != 0) begin
                v = 1'b0;
                drain();
                first = 1'b1;
            end
            send(16'($urandom), first ? -1 : B2B_GAP, first || (HOLD == 0), a0);
            first = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                v = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
        end
        v = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
